// File: rtl/pe_row_os_gen2.sv
// rtl/pe_row_os_gen2.sv - Row-stationary / output-stationary MAC processing element
// RS runs TAPS scratchpad taps then waits for a neighbour psum; OS does one MAC per start.
module pe_row_os_gen2 #(
  parameter int DATA_W  = 8,
  parameter int PSUM_W  = 10,
  parameter int TAPS    = 3,
  parameter int FRAC_SH = 6,
  parameter int SAT     = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mode_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] filter_i,
  input  logic [DATA_W-1:0] ifmap_i,
  input  logic              filter_we_i,
  input  logic              ifmap_we_i,
  input  logic [PSUM_W-1:0] psum_i,
  input  logic              psum_valid_i,
  input  logic              end_os_i,
  output logic              psum_ready_o,
  output logic [PSUM_W-1:0] psum_o,
  output logic              psum_valid_o,
  output logic              busy_o,
  output logic              overflow_o,
  output logic [DATA_W-1:0] filter_o,
  output logic [DATA_W-1:0] ifmap_o
);

  localparam int CNT_W = $clog2(TAPS);
  localparam int PW    = 2 * DATA_W;
  localparam int XW    = (PW > PSUM_W + 1) ? PW : PSUM_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WAIT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  counter;
  logic [PSUM_W-1:0] acc;
  logic [DATA_W-1:0] spad_f [TAPS];
  logic [DATA_W-1:0] spad_i [TAPS];

  logic [DATA_W-1:0] tap_f, tap_i;
  logic signed [XW-1:0] prod_full, prod_sh;
  logic [PSUM_W:0]   prod_w;
  logic [PSUM_W-1:0] acc_base;
  logic [PSUM_W:0]   mac_r, fin_r;

  // Returns {overflow, result}; the sum is formed one bit wider than the accumulator.
  function automatic logic [PSUM_W:0] sat_add(input logic [PSUM_W-1:0] a, input logic [PSUM_W:0] b);
    logic [PSUM_W:0] s;
    logic            ov;
    s  = {a[PSUM_W-1], a} + b;
    ov = s[PSUM_W] ^ s[PSUM_W-1];
    if (ov && SAT != 0)
      return {1'b1, s[PSUM_W], {(PSUM_W-1){~s[PSUM_W]}}};
    return {ov, s[PSUM_W-1:0]};
  endfunction

  assign filter_o = spad_f[0];
  assign ifmap_o  = spad_i[0];

  always_comb begin
    tap_f = spad_f[0];
    tap_i = spad_i[0];
    if (state_q == S_MAC) begin
      for (int k = 0; k < TAPS; k++) begin
        if (counter == CNT_W'(k)) begin
          tap_f = spad_f[k];
          tap_i = spad_i[k];
        end
      end
    end
  end

  always_comb begin
    prod_full = $signed({{(XW-DATA_W){tap_f[DATA_W-1]}}, tap_f})
              * $signed({{(XW-DATA_W){tap_i[DATA_W-1]}}, tap_i});
    prod_sh   = prod_full >>> FRAC_SH;
    prod_w    = prod_sh[PSUM_W:0];
    // An OS clear together with start restarts the accumulation from this product.
    acc_base  = (state_q == S_IDLE && !mode_i && end_os_i) ? '0 : acc;
    mac_r     = sat_add(acc_base, prod_w);
    fin_r     = sat_add(acc, {psum_i[PSUM_W-1], psum_i});
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i && mode_i) state_d = S_MAC;
      S_MAC:   if (counter == CNT_W'(TAPS - 1)) state_d = S_WAIT;
      S_WAIT:  if (psum_valid_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state_q != S_IDLE);
    psum_ready_o = (state_q == S_WAIT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      counter      <= '0;
      acc          <= '0;
      psum_o       <= '0;
      psum_valid_o <= 1'b0;
      overflow_o   <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        spad_f[k] <= '0;
        spad_i[k] <= '0;
      end
    end else begin
      psum_valid_o <= 1'b0;
      if (!busy_o && filter_we_i) begin
        for (int k = TAPS - 1; k > 0; k--) spad_f[k] <= spad_f[k-1];
        spad_f[0] <= filter_i;
      end
      if (!busy_o && ifmap_we_i) begin
        for (int k = TAPS - 1; k > 0; k--) spad_i[k] <= spad_i[k-1];
        spad_i[0] <= ifmap_i;
      end
      case (state_q)
        S_IDLE: begin
          if (start_i && mode_i) begin
            counter    <= '0;
            acc        <= '0;
            overflow_o <= 1'b0;
          end else if (!mode_i && start_i) begin
            acc          <= mac_r[PSUM_W-1:0];
            psum_o       <= mac_r[PSUM_W-1:0];
            psum_valid_o <= 1'b1;
            if (mac_r[PSUM_W]) overflow_o <= 1'b1;
          end else if (!mode_i && end_os_i) begin
            acc <= '0;
          end
        end
        S_MAC: begin
          acc     <= mac_r[PSUM_W-1:0];
          counter <= counter + 1'b1;
          if (mac_r[PSUM_W]) overflow_o <= 1'b1;
        end
        S_WAIT: begin
          if (psum_valid_i) begin
            psum_o       <= fin_r[PSUM_W-1:0];
            acc          <= '0;
            psum_valid_o <= 1'b1;
            if (fin_r[PSUM_W]) overflow_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_row_os_gen2.sv
// tb/tb_pe_row_os_gen2.sv - Directed bench for pe_row_os_gen2
// Three builds share stimulus: default, SAT=0 and TAPS=2.
module tb_pe_row_os_gen2;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       mode_i = 1'b0, start_i = 1'b0;
  logic [7:0] filter_i = '0, ifmap_i = '0;
  logic       filter_we_i = 1'b0, ifmap_we_i = 1'b0;
  logic [9:0] psum_i = '0;
  logic       psum_valid_i = 1'b0, end_os_i = 1'b0;

  logic       ready_a [3];
  logic [9:0] psum_a  [3];
  logic       valid_a [3];
  logic       busy_a  [3];
  logic       ovf_a   [3];
  logic [7:0] fo_a    [3];
  logic [7:0] io_a    [3];

  int checks = 0, errors = 0;
  int w_cyc [3], v_cyc [3], pulses [3], p_cap [3], o_cap [3];

  typedef struct {
    int f, i0, i1, i2, pin;
    int e0, o0, e1, o1, e2, o2;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  pe_row_os_gen2 #(.DATA_W(8), .PSUM_W(10), .TAPS(3), .FRAC_SH(6), .SAT(1)) dut0 (
    .clk_i(clk), .rst_i(rst_i), .mode_i(mode_i), .start_i(start_i),
    .filter_i(filter_i), .ifmap_i(ifmap_i), .filter_we_i(filter_we_i), .ifmap_we_i(ifmap_we_i),
    .psum_i(psum_i), .psum_valid_i(psum_valid_i), .end_os_i(end_os_i),
    .psum_ready_o(ready_a[0]), .psum_o(psum_a[0]), .psum_valid_o(valid_a[0]),
    .busy_o(busy_a[0]), .overflow_o(ovf_a[0]), .filter_o(fo_a[0]), .ifmap_o(io_a[0]));

  pe_row_os_gen2 #(.DATA_W(8), .PSUM_W(10), .TAPS(3), .FRAC_SH(6), .SAT(0)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .mode_i(mode_i), .start_i(start_i),
    .filter_i(filter_i), .ifmap_i(ifmap_i), .filter_we_i(filter_we_i), .ifmap_we_i(ifmap_we_i),
    .psum_i(psum_i), .psum_valid_i(psum_valid_i), .end_os_i(end_os_i),
    .psum_ready_o(ready_a[1]), .psum_o(psum_a[1]), .psum_valid_o(valid_a[1]),
    .busy_o(busy_a[1]), .overflow_o(ovf_a[1]), .filter_o(fo_a[1]), .ifmap_o(io_a[1]));

  pe_row_os_gen2 #(.DATA_W(8), .PSUM_W(10), .TAPS(2), .FRAC_SH(6), .SAT(1)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .mode_i(mode_i), .start_i(start_i),
    .filter_i(filter_i), .ifmap_i(ifmap_i), .filter_we_i(filter_we_i), .ifmap_we_i(ifmap_we_i),
    .psum_i(psum_i), .psum_valid_i(psum_valid_i), .end_os_i(end_os_i),
    .psum_ready_o(ready_a[2]), .psum_o(psum_a[2]), .psum_valid_o(valid_a[2]),
    .busy_o(busy_a[2]), .overflow_o(ovf_a[2]), .filter_o(fo_a[2]), .ifmap_o(io_a[2]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1; start_i = 1'b0; mode_i = 1'b0; end_os_i = 1'b0;
    filter_we_i = 1'b0; ifmap_we_i = 1'b0; psum_valid_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic load(input vec_t v);
    int iv [3];
    iv[0] = v.i0; iv[1] = v.i1; iv[2] = v.i2;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      filter_i = 8'(v.f); ifmap_i = 8'(iv[k]);
      filter_we_i = 1'b1; ifmap_we_i = 1'b1;
    end
    @(negedge clk);
    filter_we_i = 1'b0; ifmap_we_i = 1'b0;
  endtask

  // Start is in cycle 0; cycle t is observed at the negedge following posedge t-1.
  task automatic rs_exec(input int pin);
    for (int d = 0; d < 3; d++) begin
      w_cyc[d] = -1; v_cyc[d] = -1; pulses[d] = 0; p_cap[d] = 0; o_cap[d] = 0;
    end
    mode_i = 1'b1; start_i = 1'b1; psum_i = 10'(pin); psum_valid_i = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      @(negedge clk);
      start_i = 1'b0;
      for (int d = 0; d < 3; d++) begin
        if (ready_a[d] && w_cyc[d] < 0) w_cyc[d] = t;
        if (valid_a[d]) begin
          pulses[d]++;
          if (v_cyc[d] < 0) v_cyc[d] = t;
          p_cap[d] = int'($signed(psum_a[d]));
          o_cap[d] = int'(ovf_a[d]);
        end
      end
    end
    psum_valid_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{64, 10, 20, 30, 5, 65, 0, 65, 0, 55, 0};
    vecs[1] = '{-1, 1, 1, 1, 0, -3, 0, -3, 0, -2, 0};
    vecs[2] = '{3, 21, 21, 21, 7, 7, 0, 7, 0, 7, 0};
    vecs[3] = '{127, 127, 127, 127, 300, 511, 1, 32, 1, 511, 1};
    vecs[4] = '{-128, 127, 127, 127, -300, -512, 1, -38, 1, -512, 1};
    vecs[5] = '{-128, 127, 127, 127, 0, -512, 1, 262, 1, -508, 0};

    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    chk("reset_psum", int'(psum_a[0]), 0);
    chk("reset_busy", int'(busy_a[0]), 0);

    foreach (vecs[n]) begin
      do_reset();
      load(vecs[n]);
      rs_exec(vecs[n].pin);
      chk($sformatf("v%0d_psum0", n), p_cap[0], vecs[n].e0);
      chk($sformatf("v%0d_ovf0", n), o_cap[0], vecs[n].o0);
      chk($sformatf("v%0d_wait0", n), w_cyc[0], 4);
      chk($sformatf("v%0d_valid0", n), v_cyc[0], 5);
      chk($sformatf("v%0d_pulses0", n), pulses[0], 1);
      chk($sformatf("v%0d_psum1", n), p_cap[1], vecs[n].e1);
      chk($sformatf("v%0d_ovf1", n), o_cap[1], vecs[n].o1);
      chk($sformatf("v%0d_psum2", n), p_cap[2], vecs[n].e2);
      chk($sformatf("v%0d_ovf2", n), o_cap[2], vecs[n].o2);
      chk($sformatf("v%0d_wait2", n), w_cyc[2], 3);
    end

    // Reset from a loaded, overflowed state
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("rst_psum", int'(psum_a[0]), 0);
    chk("rst_ovf", int'(ovf_a[0]), 0);
    chk("rst_ready", int'(ready_a[0]), 0);
    chk("rst_valid", int'(valid_a[0]), 0);
    chk("rst_filter_o", int'(fo_a[0]), 0);
    chk("rst_ifmap_o", int'(io_a[0]), 0);

    // OS accumulation, clear-with-start, clear alone
    do_reset();
    @(negedge clk);
    filter_i = 8'd64; ifmap_i = 8'($signed(-32)); filter_we_i = 1'b1; ifmap_we_i = 1'b1;
    @(negedge clk);
    filter_we_i = 1'b0; ifmap_we_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      mode_i = 1'b0; start_i = 1'b1; end_os_i = (k == 4);
      @(negedge clk);
      start_i = 1'b0; end_os_i = 1'b0;
      chk($sformatf("os%0d_valid", k), int'(valid_a[0]), 1);
      chk($sformatf("os%0d_psum", k), int'($signed(psum_a[0])), (k == 4) ? -32 : -32 * k);
      chk($sformatf("os%0d_busy", k), int'(busy_a[0]), 0);
    end
    end_os_i = 1'b1;
    @(negedge clk);
    end_os_i = 1'b0;
    chk("os_clear_valid", int'(valid_a[0]), 0);
    chk("os_clear_hold", int'($signed(psum_a[0])), -32);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("os_after_clear", int'($signed(psum_a[0])), -32);

    // Long WAIT with ignored writes and starts
    do_reset();
    load(vecs[0]);
    mode_i = 1'b1; start_i = 1'b1; psum_valid_i = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    chk("wait_ready", int'(ready_a[0]), 1);
    for (int t = 0; t < 10; t++) begin
      filter_i = 8'd99; filter_we_i = 1'b1; start_i = 1'b1; end_os_i = 1'b1;
      @(negedge clk);
      if (!ready_a[0] || psum_a[0] != 10'd0 || !busy_a[0] || fo_a[0] != 8'd64)
        chk($sformatf("hold%0d", t), 0, 1);
    end
    chk("hold_ready", int'(ready_a[0]), 1);
    chk("hold_filter_o", int'(fo_a[0]), 64);
    filter_we_i = 1'b0; start_i = 1'b0; end_os_i = 1'b0;
    psum_i = 10'd5; psum_valid_i = 1'b1;
    @(negedge clk);
    psum_valid_i = 1'b0;
    chk("hold_done_valid", int'(valid_a[0]), 1);
    chk("hold_done_psum", int'($signed(psum_a[0])), 65);
    @(negedge clk);
    chk("hold_pulse_end", int'(valid_a[0]), 0);
    chk("hold_idle", int'(busy_a[0]), 0);

    // Reset during MAC, then RS from zeroed scratchpads
    do_reset();
    load(vecs[0]);
    mode_i = 1'b1; start_i = 1'b1; psum_valid_i = 1'b1; psum_i = 10'd5;
    for (int t = 1; t <= 2; t++) begin
      @(negedge clk);
      start_i = 1'b0;
    end
    chk("mid_busy", int'(busy_a[0]), 1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("mid_rst_busy", int'(busy_a[0]), 0);
    chk("mid_rst_valid", int'(valid_a[0]), 0);
    chk("mid_rst_psum", int'(psum_a[0]), 0);
    chk("mid_rst_filter_o", int'(fo_a[0]), 0);
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (valid_a[0] || busy_a[0]) chk($sformatf("mid_quiet%0d", t), 0, 1);
    end
    psum_valid_i = 1'b0;
    rs_exec(37);
    chk("zero_psum0", p_cap[0], 37);
    chk("zero_psum2", p_cap[2], 37);
    chk("zero_ovf0", o_cap[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
